// File: rtl/m_led_pattern.sv
// -----------------------------------------------------------------------------
// m_led_pattern
//   Parametrised LED pattern generator. Drives NUM_LED board LEDs from a 5-bit
//   slide-switch bank with 8 animation modes, run/pause, direction control and
//   PWM "breathe" dimming. Animation steps advance on an internal tick that
//   fires once every TICK_DIV clocks while running.
//
// Optional build macro:
//   SW_DEBOUNCE_EN - when defined, each synchronised switch bit is filtered by
//                    a debouncer (DEBOUNCE_CYC stable cycles). Undefined: the
//                    synchronised switches are used directly.
//
// Ports:
//   clk    in   1        system clock (16 MHz), rising edge
//   reset  in   1        synchronous, active-high reset
//   SW     in   5        async switches: [4]=run, [3:1]=mode, [0]=dir
//                        (dir 0 = toward MSB, 1 = toward LSB)
//   LED    out  NUM_LED  registered LED drive, 1 = lit
// -----------------------------------------------------------------------------

`ifdef SW_DEBOUNCE_EN
// -----------------------------------------------------------------------------
// m_led_pattern_debounce
//   Single-bit debouncer. o_filt follows i_raw only after i_raw has differed
//   from o_filt for CYC consecutive clocks; shorter glitches are dropped.
//
// Ports:
//   clk     in   1  system clock
//   reset   in   1  synchronous, active-high reset (filtered value -> 0)
//   i_raw   in   1  synchronised raw input
//   o_filt  out  1  debounced output
// -----------------------------------------------------------------------------
module m_led_pattern_debounce #(
    parameter int CYC = 160000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_filt
);
    localparam int CW = $clog2(CYC + 1);

    logic [CW-1:0] r_cnt;
    logic          r_filt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (i_raw == r_filt) begin
            r_cnt  <= '0;
        end else if (r_cnt == CW'(CYC - 1)) begin
            // This is the CYC-th consecutive cycle of disagreement.
            r_filt <= i_raw;
            r_cnt  <= '0;
        end else begin
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    assign o_filt = r_filt;
endmodule
`endif

module m_led_pattern #(
    parameter int NUM_LED      = 8,
    parameter int TICK_DIV     = 4000000,
    parameter int PWM_BITS     = 4,
    parameter int DEBOUNCE_CYC = 160000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         SW,
    output logic [NUM_LED-1:0] LED
);
    typedef enum logic [2:0] {
        MODE_OFF      = 3'd0,
        MODE_ALL_ON   = 3'd1,
        MODE_BLINK    = 3'd2,
        MODE_SHIFT    = 3'd3,
        MODE_PINGPONG = 3'd4,
        MODE_COUNTER  = 3'd5,
        MODE_FILL     = 3'd6,
        MODE_BREATHE  = 3'd7
    } mode_e;

    localparam int                   CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]     TICK_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [NUM_LED-1:0]   LSB_ONE  = NUM_LED'(1);
    localparam logic [NUM_LED-1:0]   MSB_ONE  = {1'b1, {(NUM_LED-1){1'b0}}};
    localparam logic [NUM_LED-1:0]   ALL_ONES = '1;
    localparam logic [PWM_BITS-1:0]  DUTY_MAX = '1;

    if (NUM_LED < 2 || DEBOUNCE_CYC < 1) begin : g_param_check
        $error("m_led_pattern: NUM_LED must be >= 2 and DEBOUNCE_CYC >= 1");
    end

    // ---------------------------------------------------------------------
    // Switch input path: 2-flop synchroniser, optional debounce
    // ---------------------------------------------------------------------
    logic [4:0] r_sw_s1;
    logic [4:0] r_sw_s2;
    logic [4:0] w_sw;

    // The synchroniser is cleared too, so a mode selected during reset is
    // detected with the same latency as a normal switch change.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= SW;
            r_sw_s2 <= r_sw_s1;
        end
    end

`ifdef SW_DEBOUNCE_EN
    for (genvar gi = 0; gi < 5; gi++) begin : g_db
        m_led_pattern_debounce #(
            .CYC    (DEBOUNCE_CYC)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .i_raw  (r_sw_s2[gi]),
            .o_filt (w_sw[gi])
        );
    end
`else
    assign w_sw = r_sw_s2;
`endif

    logic  w_run;
    logic  w_dir;
    mode_e w_mode;

    assign w_run  = w_sw[4];
    assign w_mode = mode_e'(w_sw[3:1]);
    assign w_dir  = w_sw[0];

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    mode_e               r_mode;
    logic [NUM_LED-1:0]  r_pat;
    logic [CNT_W-1:0]    r_cnt;
    logic [PWM_BITS-1:0] r_duty;
    logic                r_br_up;
    logic                r_pp_up;
    logic [PWM_BITS-1:0] r_pwm;
    logic [NUM_LED-1:0]  r_led;

    mode_e               w_mode_nxt;
    logic [NUM_LED-1:0]  w_pat_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [PWM_BITS-1:0] w_duty_nxt;
    logic                w_br_up_nxt;
    logic                w_pp_up_nxt;
    logic [NUM_LED-1:0]  w_led_nxt;
    logic                w_mode_chg;
    logic                w_tick;
    logic                w_pwm_on;

    assign w_mode_chg = (w_mode != r_mode);
    assign w_tick     = w_run && (r_cnt == TICK_MAX);
    assign w_pwm_on   = (r_pwm < r_duty);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode  <= MODE_OFF;
            r_pat   <= '0;
            r_cnt   <= '0;
            r_duty  <= '0;
            r_br_up <= 1'b1;
            r_pp_up <= 1'b1;
            r_pwm   <= '0;
            r_led   <= '0;
        end else begin
            r_mode  <= w_mode_nxt;
            r_pat   <= w_pat_nxt;
            r_cnt   <= w_cnt_nxt;
            r_duty  <= w_duty_nxt;
            r_br_up <= w_br_up_nxt;
            r_pp_up <= w_pp_up_nxt;
            // PWM counter runs regardless of run so a paused BREATHE keeps
            // glowing at its frozen duty.
            r_pwm   <= r_pwm + PWM_BITS'(1);
            r_led   <= w_led_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state: mode re-init, divider and per-tick pattern update
    // ---------------------------------------------------------------------
    always_comb begin
        w_mode_nxt  = r_mode;
        w_pat_nxt   = r_pat;
        w_cnt_nxt   = r_cnt;
        w_duty_nxt  = r_duty;
        w_br_up_nxt = r_br_up;
        w_pp_up_nxt = r_pp_up;

        if (w_mode_chg) begin
            // Re-init takes priority over a coincident tick, which is lost.
            w_mode_nxt  = w_mode;
            w_cnt_nxt   = '0;
            w_duty_nxt  = '0;
            w_br_up_nxt = 1'b1;
            w_pp_up_nxt = 1'b1;
            case (w_mode)
                MODE_ALL_ON,
                MODE_BLINK:    w_pat_nxt = ALL_ONES;
                MODE_SHIFT:    w_pat_nxt = w_dir ? MSB_ONE : LSB_ONE;
                MODE_PINGPONG: w_pat_nxt = LSB_ONE;
                default:       w_pat_nxt = '0;
            endcase
        end else if (w_run) begin
            w_cnt_nxt = w_tick ? '0 : r_cnt + CNT_W'(1);
            if (w_tick) begin
                case (r_mode)
                    MODE_BLINK: w_pat_nxt = ~r_pat;
                    MODE_SHIFT: begin
                        if (w_dir)
                            w_pat_nxt = {r_pat[0], r_pat[NUM_LED-1:1]};
                        else
                            w_pat_nxt = {r_pat[NUM_LED-2:0], r_pat[NUM_LED-1]};
                    end
                    MODE_PINGPONG: begin
                        // Turn around on the tick that leaves an end, so each
                        // end is shown for exactly one tick.
                        if (r_pp_up && r_pat[NUM_LED-1]) begin
                            w_pp_up_nxt = 1'b0;
                            w_pat_nxt   = r_pat >> 1;
                        end else if (!r_pp_up && r_pat[0]) begin
                            w_pp_up_nxt = 1'b1;
                            w_pat_nxt   = r_pat << 1;
                        end else if (r_pp_up) begin
                            w_pat_nxt   = r_pat << 1;
                        end else begin
                            w_pat_nxt   = r_pat >> 1;
                        end
                    end
                    MODE_COUNTER: w_pat_nxt = r_pat + NUM_LED'(1);
                    MODE_FILL: begin
                        if (r_pat == ALL_ONES)
                            w_pat_nxt = '0;
                        else
                            w_pat_nxt = {r_pat[NUM_LED-2:0], 1'b1};
                    end
                    MODE_BREATHE: begin
                        if (r_br_up && r_duty == DUTY_MAX) begin
                            w_br_up_nxt = 1'b0;
                            w_duty_nxt  = r_duty - PWM_BITS'(1);
                        end else if (!r_br_up && r_duty == '0) begin
                            w_br_up_nxt = 1'b1;
                            w_duty_nxt  = r_duty + PWM_BITS'(1);
                        end else if (r_br_up) begin
                            w_duty_nxt  = r_duty + PWM_BITS'(1);
                        end else begin
                            w_duty_nxt  = r_duty - PWM_BITS'(1);
                        end
                    end
                    default: w_pat_nxt = r_pat;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------------
    // Output register source
    // ---------------------------------------------------------------------
    always_comb begin
        w_led_nxt = r_pat;
        if (r_mode == MODE_BREATHE)
            w_led_nxt = {NUM_LED{w_pwm_on}};
    end

    assign LED = r_led;
endmodule

// File: tb/tb_m_led_pattern.sv
// -----------------------------------------------------------------------------
// tb_m_led_pattern
//   Self-checking bench for m_led_pattern (NUM_LED=8, TICK_DIV=4, PWM_BITS=4).
//   Expected LED values come from closed-form functions of the tick index k
//   since the last mode init; BREATHE uses a free-running 4-bit PWM model.
// -----------------------------------------------------------------------------
module tb_m_led_pattern;
    localparam int NL = 8;
    localparam int TD = 4;
    localparam int PB = 4;
    localparam int DB_PARAM = 8;
`ifdef SW_DEBOUNCE_EN
    localparam int LAT = 4 + DB_PARAM;
`else
    localparam int LAT = 4;
`endif

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    SW    = 5'b00000;
    logic [NL-1:0] LED;

    int checks = 0;
    int errors = 0;

    // PWM model: counter cleared by reset, +1 every clock. pwm_before holds
    // the count that was current just before the latest edge.
    logic [3:0] pwm_m      = 4'd0;
    logic [3:0] pwm_before = 4'd0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pwm_before <= pwm_m;
        pwm_m      <= reset ? 4'd0 : pwm_m + 4'd1;
    end

    m_led_pattern #(
        .NUM_LED      (NL),
        .TICK_DIV     (TD),
        .PWM_BITS     (PB),
        .DEBOUNCE_CYC (DB_PARAM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .SW    (SW),
        .LED   (LED)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pattern value k ticks after init for the non-PWM modes.
    function automatic logic [7:0] exp_pat(input int mode, input int k);
        int p;
        case (mode)
            1: return 8'hFF;
            2: return (k % 2 == 0) ? 8'hFF : 8'h00;
            4: begin
                p = k % 14;
                return 8'(1 << ((p < 8) ? p : 14 - p));
            end
            5: return 8'(k % 256);
            6: return 8'((1 << (k % 9)) - 1);
            default: return 8'h00;
        endcase
    endfunction

    // Breathe duty k ticks after init: 0..15, 14..1, then repeat (period 30).
    function automatic int duty_of(input int k);
        int p;
        p = k % 30;
        return (p <= 15) ? p : 30 - p;
    endfunction

    function automatic logic [7:0] exp_pwm(input int duty);
        return (int'(pwm_before) < duty) ? 8'hFF : 8'h00;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        SW    = 5'b10100;                       // run, BLINK
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (LED !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got %h want 00", i, LED);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < LAT - 1; i++) begin
            step();
            checks++;
            if (LED !== 8'h00) begin
                errors++;
                $display("FAIL post_reset_off cyc=%0d got %h want 00", i, LED);
            end
        end
        step();
        for (int k = 0; k < 6; k++)
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (LED !== exp_pat(2, k)) begin
                    errors++;
                    $display("FAIL blink k=%0d c=%0d got %h want %h", k, c, LED, exp_pat(2, k));
                end
                step();
            end
    endtask

    // Entered at a tick-aligned point, so the mode change lands on the same
    // edge as a BLINK tick: the init must win and the divider restart.
    task automatic test_shift();
        int pos;
        int dir;
        SW = 5'b10110;
        repeat (LAT) step();
        pos = 0;
        dir = 0;
        for (int k = 0; k <= 20; k++) begin
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (LED !== 8'(1 << pos)) begin
                    errors++;
                    $display("FAIL shift k=%0d c=%0d got %h want %h", k, c, LED, 8'(1 << pos));
                end
                if (k == 15 && c == 0) begin
                    SW[0] = 1'b1;                   // LED is 0x80 here
                    dir   = 1;
                end
                step();
            end
            pos = dir ? (pos + 7) % 8 : (pos + 1) % 8;
        end
        SW = 5'b10000;
        repeat (LAT) step();
        checks++;
        if (LED !== 8'h00) begin
            errors++;
            $display("FAIL shift_off got %h want 00", LED);
        end
        SW = 5'b10111;
        repeat (LAT) step();
        pos = 7;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (LED !== 8'(1 << pos)) begin
                    errors++;
                    $display("FAIL shift_lsb k=%0d c=%0d got %h want %h", k, c, LED, 8'(1 << pos));
                end
                step();
            end
            pos = (pos + 7) % 8;
        end
    endtask

    task automatic test_pingpong();
        SW = {4'b1100, 1'($urandom_range(0, 1))};
        repeat (LAT) step();
        for (int k = 0; k <= 30; k++)
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (LED !== exp_pat(4, k)) begin
                    errors++;
                    $display("FAIL pingpong k=%0d c=%0d got %h want %h", k, c, LED, exp_pat(4, k));
                end
                if (k == 10 && c == 0) SW[0] = ~SW[0];   // dir must be ignored
                step();
            end
    endtask

    task automatic test_counter_pause();
        int kp;
        int len;
        kp  = $urandom_range(3, 20);
        len = $urandom_range(20, 60);
        SW  = 5'b11010;
        repeat (LAT) step();
        for (int k = 0; k < kp; k++)
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (LED !== exp_pat(5, k)) begin
                    errors++;
                    $display("FAIL counter k=%0d c=%0d got %h want %h", k, c, LED, exp_pat(5, k));
                end
                step();
            end
        SW[4] = 1'b0;
        for (int i = 0; i < len; i++) begin
            checks++;
            if (LED !== 8'(kp)) begin
                errors++;
                $display("FAIL counter_pause i=%0d got %h want %h", i, LED, 8'(kp));
            end
            step();
        end
        SW[4] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (LED !== 8'(kp)) begin
                errors++;
                $display("FAIL counter_resume_hold i=%0d got %h want %h", i, LED, 8'(kp));
            end
            step();
        end
        for (int k = kp + 1; k <= 257; k++)
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (LED !== exp_pat(5, k)) begin
                    errors++;
                    $display("FAIL counter_run k=%0d c=%0d got %h want %h", k, c, LED, exp_pat(5, k));
                end
                step();
            end
    endtask

    task automatic test_breathe();
        int lit;
        SW = 5'b11110;
        repeat (LAT) step();
        for (int k = 0; k <= 31; k++)
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (LED !== exp_pwm(duty_of(k))) begin
                    errors++;
                    $display("FAIL breathe k=%0d c=%0d got %h want %h", k, c, LED, exp_pwm(duty_of(k)));
                end
                step();
            end
        // Second pass: pause at full duty and measure the on-ratio.
        SW = 5'b10000;
        repeat (LAT) step();
        SW = 5'b11110;
        repeat (LAT) step();
        for (int k = 0; k <= 15; k++)
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (LED !== exp_pwm(duty_of(k))) begin
                    errors++;
                    $display("FAIL breathe2 k=%0d c=%0d got %h want %h", k, c, LED, exp_pwm(duty_of(k)));
                end
                if (k == 15 && c == 0) SW[4] = 1'b0;
                step();
            end
        lit = 0;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (LED !== exp_pwm(15)) begin
                errors++;
                $display("FAIL breathe_pause i=%0d got %h want %h", i, LED, exp_pwm(15));
            end
            if (LED === 8'hFF) lit++;
            step();
        end
        checks++;
        if (lit != 30) begin
            errors++;
            $display("FAIL breathe_pause_ratio got %0d want 30 lit of 32", lit);
        end
        SW[4] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (LED !== exp_pwm(15)) begin
                errors++;
                $display("FAIL breathe_resume i=%0d got %h want %h", i, LED, exp_pwm(15));
            end
            step();
        end
        for (int k = 16; k <= 20; k++)
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (LED !== exp_pwm(duty_of(k))) begin
                    errors++;
                    $display("FAIL breathe_down k=%0d c=%0d got %h want %h", k, c, LED, exp_pwm(duty_of(k)));
                end
                step();
            end
    endtask

    task automatic test_fill_reset();
        SW = 5'b11100;
        repeat (LAT) step();
        for (int k = 0; k < 12; k++)
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (LED !== exp_pat(6, k)) begin
                    errors++;
                    $display("FAIL fill k=%0d c=%0d got %h want %h", k, c, LED, exp_pat(6, k));
                end
                step();
            end
        checks++;
        if (LED !== 8'h07) begin
            errors++;
            $display("FAIL fill_pre_reset got %h want 07", LED);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (LED !== 8'h00) begin
            errors++;
            $display("FAIL fill_reset got %h want 00", LED);
        end
        repeat (LAT) step();
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (LED !== exp_pat(6, k)) begin
                    errors++;
                    $display("FAIL fill_restart k=%0d c=%0d got %h want %h", k, c, LED, exp_pat(6, k));
                end
                step();
            end
    endtask

    // Mode changes are honoured even while paused.
    task automatic test_static();
        SW = 5'b00010;
        repeat (LAT) step();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (LED !== 8'hFF) begin
                errors++;
                $display("FAIL all_on i=%0d got %h want ff", i, LED);
            end
            step();
        end
        SW = 5'b00000;
        repeat (LAT) step();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (LED !== 8'h00) begin
                errors++;
                $display("FAIL off i=%0d got %h want 00", i, LED);
            end
            step();
        end
    endtask

`ifdef SW_DEBOUNCE_EN
    task automatic test_debounce();
        SW = 5'b10010;                          // ALL_ON
        repeat (LAT) step();
        SW[3] = 1'b1;                           // short glitch towards COUNTER
        repeat (5) step();
        SW[3] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (LED !== 8'hFF) begin
                errors++;
                $display("FAIL debounce_glitch i=%0d got %h want ff", i, LED);
            end
            step();
        end
        SW[3] = 1'b1;
        for (int i = 1; i <= LAT; i++) begin
            step();
            checks++;
            if (LED !== ((i < LAT) ? 8'hFF : 8'h00)) begin
                errors++;
                $display("FAIL debounce_change i=%0d got %h want %h", i, LED, (i < LAT) ? 8'hFF : 8'h00);
            end
        end
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (LED !== exp_pat(5, k)) begin
                    errors++;
                    $display("FAIL debounce_counter k=%0d c=%0d got %h want %h", k, c, LED, exp_pat(5, k));
                end
                step();
            end
    endtask
`endif

    initial begin
        test_reset();
`ifdef SW_DEBOUNCE_EN
        test_debounce();
        test_static();
`else
        test_shift();
        test_pingpong();
        test_counter_pause();
        test_breathe();
        test_fill_reset();
        test_static();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
